// File: rtl/operand_seq_ctrl.sv
// operand_seq_ctrl: sequences operand loading into two SIPO banks (scalar,
// then point), launches the arithmetic core, waits for completion, and streams
// the result words out.
//
// Handshakes: a word moves on a port only in a cycle where valid and ready are
// both high at the rising clock edge; a producer holding valid keeps its data
// stable until that cycle, and ready may depend combinationally on state only.
module operand_seq_ctrl #(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int N_REG_BITS   = $clog2(N_REG)
) (
  input  logic                    clk,
  input  logic                    rst,
  // input word stream
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [R_DATA_WIDTH-1:0] in_data,
  // operand bank write port
  output logic [1:0]              sipo_load,
  output logic [N_REG_BITS-1:0]   sipo_addr,
  output logic [R_DATA_WIDTH-1:0] sipo_din,
  // core control
  output logic                    core_start,
  input  logic                    core_done,
  // result read port
  output logic [N_REG_BITS-1:0]   res_addr,
  input  logic [R_DATA_WIDTH-1:0] res_word,
  // result word stream
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [R_DATA_WIDTH-1:0] out_data,
  // status and debug
  output logic                    busy,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    LOAD_K = 3'd0,
    LOAD_U = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam logic [N_REG_BITS-1:0] CNT_LAST = N_REG_BITS'(N_REG - 1);

  state_t                state, state_next;
  logic [N_REG_BITS-1:0] cnt, cnt_next;
  logic                  in_hs, out_hs;

  // State and word counter register; reset returns to an idle scalar load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_K;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and output decode; every control output is forced low while rst is high.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    sipo_load  = 2'b00;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    in_hs      = 1'b0;
    out_hs     = 1'b0;

    if (!rst) begin
      busy = !((state == LOAD_K) && (cnt == '0));
      unique case (state)
        LOAD_K, LOAD_U: begin
          in_ready = 1'b1;
          in_hs    = in_valid;
          if (in_hs) begin
            sipo_load = (state == LOAD_K) ? 2'b01 : 2'b10;
            if (cnt == CNT_LAST) begin
              cnt_next   = '0;
              state_next = (state == LOAD_K) ? LOAD_U : START;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        START: begin
          core_start = 1'b1;
          state_next = WAIT;
        end
        WAIT: begin
          if (core_done) begin
            cnt_next   = '0;
            state_next = SEND;
          end
        end
        SEND: begin
          out_valid = 1'b1;
          out_hs    = out_ready;
          if (out_hs) begin
            if (cnt == CNT_LAST) begin
              cnt_next   = '0;
              state_next = LOAD_K;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        default: begin
          cnt_next   = '0;
          state_next = LOAD_K;
        end
      endcase
    end
  end

  // Address and data paths are pure wiring; only the strobes qualify them.
  assign sipo_addr = cnt;
  assign sipo_din  = in_data;
  assign res_addr  = cnt;
  assign out_data  = res_word;
  assign state_dbg = state;

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Directed bench for operand_seq_ctrl (N_REG = 8, 32-bit words).
module tb_operand_seq_ctrl;

  localparam int W  = 32;
  localparam int NR = 8;
  localparam int AB = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    sipo_load;
  logic [AB-1:0] sipo_addr;
  logic [W-1:0]  sipo_din;
  logic          core_start;
  logic          core_done;
  logic [AB-1:0] res_addr;
  logic [W-1:0]  res_word;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic [2:0]    state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  operand_seq_ctrl #(.R_DATA_WIDTH(W), .N_REG(NR), .N_REG_BITS(AB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sipo_load  (sipo_load),
    .sipo_addr  (sipo_addr),
    .sipo_din   (sipo_din),
    .core_start (core_start),
    .core_done  (core_done),
    .res_addr   (res_addr),
    .res_word   (res_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // core result memory model: word = 0xA0 + address
  assign res_word = 32'hA0 + W'(res_addr);

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic         done;
    logic [W-1:0] d;
    logic [1:0]   ld;
    logic [AB-1:0] addr;
    logic         bz;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic v, input logic done, input logic [W-1:0] d,
                         input logic [1:0] ld, input logic [AB-1:0] addr, input logic bz);
    vec_t r;
    r.v = v; r.done = done; r.d = d; r.ld = ld; r.addr = addr; r.bz = bz;
    vecs.push_back(r);
  endtask

  // Load n consecutive words from base starting at scalar address 0.
  task automatic load_words(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = W'(base + k);
      @(negedge clk);
      chk("ld_strobe", W'(sipo_load), (k < NR) ? 32'd1 : 32'd2);
      chk("ld_addr",   W'(sipo_addr), W'(k % NR));
      chk("ld_din",    sipo_din, W'(base + k));
      chk("ld_ready",  W'(in_ready), 32'd1);
      tick();
    end
  endtask

  // Expects START now; runs WAIT with done 5 cycles after start, then drains SEND.
  task automatic run_core();
    int i;
    int cyc;
    in_valid = 1'b1;
    in_data  = 32'h55;
    @(negedge clk);
    chk("start_pulse", W'(core_start), 32'd1);
    chk("start_ready", W'(in_ready), 32'd0);
    chk("start_load",  W'(sipo_load), 32'd0);
    chk("start_state", W'(state_dbg), 32'd2);
    tick();
    for (int j = 1; j <= 5; j++) begin
      core_done = (j == 5);
      @(negedge clk);
      chk("wait_start", W'(core_start), 32'd0);
      chk("wait_ready", W'(in_ready), 32'd0);
      chk("wait_load",  W'(sipo_load), 32'd0);
      chk("wait_ovld",  W'(out_valid), 32'd0);
      chk("wait_busy",  W'(busy), 32'd1);
      tick();
    end
    core_done = 1'b0;
    i = 0;
    cyc = 0;
    while (i < NR && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("send_valid", W'(out_valid), 32'd1);
      chk("send_data",  out_data, 32'hA0 + W'(i));
      chk("send_raddr", W'(res_addr), W'(i));
      chk("send_ready", W'(in_ready), 32'd0);
      chk("send_load",  W'(sipo_load), 32'd0);
      if (out_ready) i++;
      cyc++;
      tick();
    end
    chk("send_timeout", W'(i), W'(NR));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("idle_busy",  W'(busy), 32'd0);
    chk("idle_ready", W'(in_ready), 32'd1);
    chk("idle_ovld",  W'(out_valid), 32'd0);
    chk("idle_state", W'(state_dbg), 32'd0);
    tick();
  endtask

  initial begin
    // vectors: valid toggle on first words, core_done pulse ignored in LOAD_U
    add_vec(1, 0, 32'h00, 2'b01, 3'd0, 1'b0);
    add_vec(0, 0, 32'hFF, 2'b00, 3'd1, 1'b1);
    add_vec(1, 0, 32'h01, 2'b01, 3'd1, 1'b1);
    add_vec(0, 0, 32'hFF, 2'b00, 3'd2, 1'b1);
    for (int k = 2; k < 8; k++)   add_vec(1, 0, W'(k), 2'b01, AB'(k), 1'b1);
    for (int k = 8; k < 11; k++)  add_vec(1, 0, W'(k), 2'b10, AB'(k - 8), 1'b1);
    add_vec(0, 1, 32'hEE, 2'b00, 3'd3, 1'b1);
    add_vec(0, 0, 32'hEE, 2'b00, 3'd3, 1'b1);
    for (int k = 11; k < 16; k++) add_vec(1, 0, W'(k), 2'b10, AB'(k - 8), 1'b1);

    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h33;
    core_done = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", W'(in_ready), 32'd0);
    chk("rst_load",  W'(sipo_load), 32'd0);
    chk("rst_start", W'(core_start), 32'd0);
    chk("rst_ovld",  W'(out_valid), 32'd0);
    chk("rst_busy",  W'(busy), 32'd0);
    chk("rst_state", W'(state_dbg), 32'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;

    // table-driven load phase
    foreach (vecs[n]) begin
      in_valid  = vecs[n].v;
      core_done = vecs[n].done;
      in_data   = vecs[n].d;
      @(negedge clk);
      chk("vec_load",  W'(sipo_load), W'(vecs[n].ld));
      chk("vec_addr",  W'(sipo_addr), W'(vecs[n].addr));
      chk("vec_din",   sipo_din, vecs[n].d);
      chk("vec_ready", W'(in_ready), 32'd1);
      chk("vec_start", W'(core_start), 32'd0);
      chk("vec_busy",  W'(busy), W'(vecs[n].bz));
      chk("vec_ovld",  W'(out_valid), 32'd0);
      tick();
    end
    core_done = 1'b0;
    run_core();

    // reset in the middle of the point bank, then a clean full sequence
    load_words(NR + 3, 32'h20);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_load",  W'(sipo_load), 32'd0);
    chk("midrst_ready", W'(in_ready), 32'd0);
    chk("midrst_busy",  W'(busy), 32'd0);
    tick();
    rst = 1'b0;
    load_words(2 * NR, 32'h40);
    run_core();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
